// File: rtl/pb_gpio_irq_pkg.sv
// ----------------------------------------------------------------------------
// pb_gpio_irq_pkg
//   Shared constants for the PacoBlaze GPIO/interrupt responder:
//   register offsets (relative to BASE_ADDR), reset values and the
//   encoding of the interrupt handshake states.
//   Build option: PB_GPIO_IRQ_ACK_EN selects the acknowledge handshake
//   (uses pb_irq_state_e); otherwise a fixed-length irq pulse is used.
// ----------------------------------------------------------------------------
package pb_gpio_irq_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [7:0] PB_GPIO_DATA_IN  = 8'd0;
  localparam logic [7:0] PB_GPIO_DATA_OUT = 8'd1;
  localparam logic [7:0] PB_GPIO_MASK     = 8'd2;
  localparam logic [7:0] PB_GPIO_FLAGS    = 8'd3;
  localparam logic [7:0] PB_GPIO_EDGE     = 8'd4;

  // Highest decoded offset
  localparam logic [7:0] PB_GPIO_LAST_OFF = PB_GPIO_EDGE;

  // Reset values of the configuration registers
  localparam logic [7:0] PB_GPIO_MASK_RST  = 8'h00;
  localparam logic [7:0] PB_GPIO_FLAGS_RST = 8'h00;
  localparam logic [7:0] PB_GPIO_EDGE_RST  = 8'hFF;

  // Interrupt handshake states (acknowledge build)
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } pb_irq_state_e;

endpackage

// File: rtl/pb_gpio_irq_sync_edge.sv
// ----------------------------------------------------------------------------
// pb_sync_edge
//   8-bit two-flop synchroniser for an asynchronous input port, followed by
//   a "previous value" register and a per-bit edge polarity select.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     i_pins[7:0]   asynchronous input pins
//     i_edge_sel    per-bit polarity: 1 = rising edge, 0 = falling edge
//     o_sync[7:0]   synchronised pin value (second flop)
//     o_event[7:0]  one-cycle event per bit of the selected polarity
// ----------------------------------------------------------------------------
module pb_sync_edge
  import pb_gpio_irq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_pins,
  input  logic [7:0] i_edge_sel,
  output logic [7:0] o_sync,
  output logic [7:0] o_event
);

  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_prev;

  // Clearing the chain to zero means a pin already high at reset produces
  // exactly one rising event after release; software relies on seeing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
      r_prev  <= 8'h00;
    end else begin
      r_sync1 <= i_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  logic [7:0] w_rise;
  logic [7:0] w_fall;

  assign w_rise  = r_sync2 & ~r_prev;
  assign w_fall  = ~r_sync2 & r_prev;
  assign o_sync  = r_sync2;
  assign o_event = (i_edge_sel & w_rise) | (~i_edge_sel & w_fall);

endmodule

// File: rtl/pb_gpio_irq.sv
// ----------------------------------------------------------------------------
// pb_gpio_irq
//   Port-bus responder for the PacoBlaze core. Serves five registers at
//   BASE_ADDR..BASE_ADDR+4 (DATA_IN, DATA_OUT, MASK, FLAGS, EDGE), drives a
//   registered output port, samples an asynchronous input port with edge
//   detection and raises the core's interrupt request from masked flags.
//   Build option: PB_GPIO_IRQ_ACK_EN
//     defined   : irq is held until the core acknowledges with iak
//     undefined : irq is a retriggerable pulse of IRQ_PULSE cycles, no iak
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     port_id[7:0]    port address from the core
//     write_strobe    write qualifier
//     read_strobe     read qualifier (reads are side-effect free)
//     out_port[7:0]   write data from the core
//     in_port[7:0]    registered read data to the core
//     irq             interrupt request
//     iak             interrupt acknowledge (PB_GPIO_IRQ_ACK_EN only)
//     portA_out[7:0]  general output port
//     portB_in[7:0]   asynchronous general input port
// ----------------------------------------------------------------------------
module pb_gpio_irq
  import pb_gpio_irq_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter logic [7:0] OUT_RESET = 8'h00,
  parameter int         IRQ_PULSE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       irq,
`ifdef PB_GPIO_IRQ_ACK_EN
  input  logic       iak,
`endif
  output logic [7:0] portA_out,
  input  logic [7:0] portB_in
);

  // Reads are served every cycle from port_id alone, so the strobe is
  // not needed by the datapath.
  logic w_unused_rd;
  assign w_unused_rd = read_strobe;

  // Address decode: offset wraps modulo 256 so any BASE_ADDR works.
  logic [7:0] w_off;
  logic       w_hit;

  assign w_off = port_id - BASE_ADDR;
  assign w_hit = (w_off <= PB_GPIO_LAST_OFF);

  logic w_wr_out;
  logic w_wr_mask;
  logic w_wr_flags;
  logic w_wr_edge;

  assign w_wr_out   = write_strobe && (w_off == PB_GPIO_DATA_OUT);
  assign w_wr_mask  = write_strobe && (w_off == PB_GPIO_MASK);
  assign w_wr_flags = write_strobe && (w_off == PB_GPIO_FLAGS);
  assign w_wr_edge  = write_strobe && (w_off == PB_GPIO_EDGE);

  logic [7:0] r_data_out;
  logic [7:0] r_mask;
  logic [7:0] r_flags;
  logic [7:0] r_edge;
  logic [7:0] r_in_port;

  logic [7:0] w_sync;
  logic [7:0] w_event;

  pb_sync_edge u_sync_edge (
    .clk        (clk),
    .rst        (rst),
    .i_pins     (portB_in),
    .i_edge_sel (r_edge),
    .o_sync     (w_sync),
    .o_event    (w_event)
  );

  // Write-one-to-clear vector; zero unless FLAGS is being written.
  logic [7:0] w_w1c;
  assign w_w1c = w_wr_flags ? out_port : 8'h00;

  // A new interrupt cause is either a fresh enabled event or a MASK write
  // that exposes a flag which was already pending but masked.
  logic w_unmask_evt;
  logic w_new_evt;

  assign w_unmask_evt = w_wr_mask && (|(out_port & ~r_mask & r_flags));
  assign w_new_evt    = (|(w_event & r_mask)) || w_unmask_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= OUT_RESET;
      r_mask     <= PB_GPIO_MASK_RST;
      r_flags    <= PB_GPIO_FLAGS_RST;
      r_edge     <= PB_GPIO_EDGE_RST;
    end else begin
      if (w_wr_out)  r_data_out <= out_port;
      if (w_wr_mask) r_mask     <= out_port;
      if (w_wr_edge) r_edge     <= out_port;
      // Set dominates clear so an edge coinciding with a W1C is not lost.
      r_flags <= (r_flags & ~w_w1c) | w_event;
    end
  end

  // Read mux, registered once to give the core one cycle of latency.
  logic [7:0] w_rd_data;

  always_comb begin
    w_rd_data = 8'h00;
    if (w_hit) begin
      case (w_off)
        PB_GPIO_DATA_IN:  w_rd_data = w_sync;
        PB_GPIO_DATA_OUT: w_rd_data = r_data_out;
        PB_GPIO_MASK:     w_rd_data = r_mask;
        PB_GPIO_FLAGS:    w_rd_data = r_flags;
        PB_GPIO_EDGE:     w_rd_data = r_edge;
        default:          w_rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_port <= 8'h00;
    else     r_in_port <= w_rd_data;
  end

  assign in_port   = r_in_port;
  assign portA_out = r_data_out;

`ifdef PB_GPIO_IRQ_ACK_EN
  pb_irq_state_e r_state;
  pb_irq_state_e w_state_nxt;
  logic          w_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A cause arriving alongside iak keeps the request asserted, so the
  // event is not lost while the core retires the previous one.
  always_comb begin
    w_state_nxt = r_state;
    w_irq       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_new_evt) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_irq = 1'b1;
        if (iak) w_state_nxt = w_new_evt ? ST_REQ : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign irq = w_irq;
`else
  localparam int CNT_W = $clog2(IRQ_PULSE + 1);

  logic [CNT_W-1:0] r_cnt;

  // Retriggerable down-counter: each new cause restarts the full pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_new_evt) begin
      r_cnt <= CNT_W'(IRQ_PULSE);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign irq = (r_cnt != '0);
`endif

endmodule

// File: tb/tb_pb_gpio_irq.sv
module tb_pb_gpio_irq;

  localparam logic [7:0] BASE  = 8'h10;
  localparam logic [7:0] ORST  = 8'h3C;
  localparam logic [7:0] IDLE_ID = 8'hF0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       irq;
  logic [7:0] portA_out;
  logic [7:0] portB_in;
`ifdef PB_GPIO_IRQ_ACK_EN
  logic       iak;
`endif

  int checks   = 0;
  int failures = 0;

  pb_gpio_irq #(
    .BASE_ADDR (BASE),
    .OUT_RESET (ORST),
    .IRQ_PULSE (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .irq          (irq),
`ifdef PB_GPIO_IRQ_ACK_EN
    .iak          (iak),
`endif
    .portA_out    (portA_out),
    .portB_in     (portB_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Write: strobe is seen at the next rising edge; returns on the
  // following falling edge with the bus idle again.
  task automatic bus_write(input logic [7:0] off, input logic [7:0] data);
    @(negedge clk);
    port_id      = BASE + off;
    out_port     = data;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    port_id      = IDLE_ID;
    out_port     = 8'h00;
  endtask

  // Read: in_port is registered at the edge after port_id is applied.
  task automatic bus_read(input logic [7:0] off, output logic [7:0] data);
    @(negedge clk);
    port_id     = BASE + off;
    read_strobe = 1'b1;
    @(negedge clk);
    data        = in_port;
    read_strobe = 1'b0;
    port_id     = IDLE_ID;
  endtask

`ifdef PB_GPIO_IRQ_ACK_EN
  task automatic ack_pulse();
    @(negedge clk);
    iak = 1'b1;
    @(negedge clk);
    iak = 1'b0;
  endtask
`endif

  typedef struct {
    logic       is_wr;
    logic [7:0] off;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [7:0] exp_pa;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [7:0] rd;
    int         hi;

    // {is_wr, off, data, exp_rd, exp_pa}; portB_in held at 0 throughout
    vecs[0]  = '{1'b0, 8'd1, 8'h00, ORST,  ORST};
    vecs[1]  = '{1'b0, 8'd2, 8'h00, 8'h00, ORST};
    vecs[2]  = '{1'b0, 8'd3, 8'h00, 8'h00, ORST};
    vecs[3]  = '{1'b0, 8'd4, 8'h00, 8'hFF, ORST};
    vecs[4]  = '{1'b0, 8'd0, 8'h00, 8'h00, ORST};
    vecs[5]  = '{1'b1, 8'd1, 8'hA5, 8'h00, 8'hA5};
    vecs[6]  = '{1'b0, 8'd1, 8'h00, 8'hA5, 8'hA5};
    vecs[7]  = '{1'b1, 8'd2, 8'h5A, 8'h00, 8'hA5};
    vecs[8]  = '{1'b0, 8'd2, 8'h00, 8'h5A, 8'hA5};
    vecs[9]  = '{1'b1, 8'd4, 8'h3C, 8'h00, 8'hA5};
    vecs[10] = '{1'b0, 8'd4, 8'h00, 8'h3C, 8'hA5};
    vecs[11] = '{1'b1, 8'd0, 8'hFF, 8'h00, 8'hA5};
    vecs[12] = '{1'b0, 8'd0, 8'h00, 8'h00, 8'hA5};
    vecs[13] = '{1'b0, 8'd5, 8'h00, 8'h00, 8'hA5};
    vecs[14] = '{1'b1, 8'd7, 8'h11, 8'h00, 8'hA5};
    vecs[15] = '{1'b0, 8'd1, 8'h00, 8'hA5, 8'hA5};
    vecs[16] = '{1'b1, 8'd2, 8'h00, 8'h00, 8'hA5};

    rst          = 1'b1;
    port_id      = IDLE_ID;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    out_port     = 8'h00;
    portB_in     = 8'h00;
`ifdef PB_GPIO_IRQ_ACK_EN
    iak          = 1'b0;
`endif

    // Reset state
    wait_neg(3);
    check("rst_porta", portA_out, ORST);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_in_port", in_port, 8'h00);
    rst = 1'b0;
    wait_neg(2);

    // Register-file vectors
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].off, vecs[i].data);
        check($sformatf("vec%0d_wr_porta", i), portA_out, vecs[i].exp_pa);
      end else begin
        bus_read(vecs[i].off, rd);
        check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        check($sformatf("vec%0d_porta", i), portA_out, vecs[i].exp_pa);
      end
    end
    check("vec_irq_idle", {7'd0, irq}, 8'h00);

    // Rising edge on bit 0, masked in: latency and pulse shape
    bus_write(8'd2, 8'h01);
    bus_write(8'd4, 8'h01);
    portB_in = 8'h01;
    @(negedge clk);
    check("t3_irq_e1", {7'd0, irq}, 8'h00);
    @(negedge clk);
    check("t3_irq_e2", {7'd0, irq}, 8'h00);
    @(negedge clk);
    check("t3_irq_e3", {7'd0, irq}, 8'h01);
`ifdef PB_GPIO_IRQ_ACK_EN
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (irq) hi++;
    end
    check("t3_irq_held", 8'(hi), 8'd8);
    ack_pulse();
    check("t3_irq_after_iak", {7'd0, irq}, 8'h00);
`else
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irq) hi++;
      else break;
    end
    check("t3_pulse_len", 8'(hi), 8'd4);
`endif
    bus_read(8'd3, rd);
    check("t3_flags_set", rd, 8'h01);
    bus_write(8'd3, 8'h01);
    bus_read(8'd3, rd);
    check("t3_flags_w1c", rd, 8'h00);

    // Falling edge on bit 7 while masked out, then unmask
    bus_write(8'd2, 8'h00);
    portB_in = 8'h81;
    wait_neg(4);
    portB_in = 8'h01;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (irq) hi++;
    end
    check("t4_irq_masked", 8'(hi), 8'd0);
    bus_read(8'd3, rd);
    check("t4_flags_fall", rd, 8'h80);
    bus_write(8'd2, 8'h80);
    check("t4_irq_unmask", {7'd0, irq}, 8'h01);
`ifdef PB_GPIO_IRQ_ACK_EN
    ack_pulse();
`else
    wait_neg(6);
`endif
    check("t4_irq_done", {7'd0, irq}, 8'h00);
    bus_write(8'd3, 8'h80);
    bus_read(8'd3, rd);
    check("t4_flags_clr", rd, 8'h00);
    bus_write(8'd2, 8'h00);

    // Set beats clear when an edge and a W1C land on the same edge
    bus_write(8'd4, 8'h05);
    portB_in = 8'h05;
    wait_neg(4);
    bus_read(8'd3, rd);
    check("t5_flag2_set", rd, 8'h04);
    portB_in = 8'h01;
    wait_neg(4);
    portB_in = 8'h05;
    wait_neg(2);
    port_id      = BASE + 8'd3;
    out_port     = 8'h04;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    port_id      = IDLE_ID;
    out_port     = 8'h00;
    bus_read(8'd3, rd);
    check("t5_set_wins", rd, 8'h04);
    bus_write(8'd3, 8'h04);
    bus_read(8'd3, rd);
    check("t5_w1c_alone", rd, 8'h00);

    // Asynchronous reset while irq is asserted
    portB_in = 8'h00;
    wait_neg(4);
    bus_write(8'd2, 8'h01);
    portB_in = 8'h01;
    wait_neg(3);
    check("t6_irq_before", {7'd0, irq}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    check("t6_irq_async", {7'd0, irq}, 8'h00);
    check("t6_porta_async", portA_out, ORST);
    check("t6_in_port_async", in_port, 8'h00);
    wait_neg(2);
    rst = 1'b0;
    bus_read(8'd2, rd);
    check("t6_mask", rd, 8'h00);
    bus_read(8'd4, rd);
    check("t6_edge", rd, 8'hFF);
    bus_read(8'd1, rd);
    check("t6_out", rd, ORST);
    // Pin held high through reset produces one rising event afterwards
    bus_read(8'd3, rd);
    check("t6_flags_post", rd, 8'h01);
    check("t6_irq_post", {7'd0, irq}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
